// File: rtl/ad_ip_jesd204_tpl_dac_channel_src.sv
// ad_ip_jesd204_tpl_dac_channel_src: per-channel DAC sample source (DMA, zero, pattern, ramp, PN7, PN15)
// Ports:
//   clk, reset         link clock, synchronous active-high reset
//   enable, data_sel   channel enable and source select (0 DMA, 1/6/7 zero, 2 pattern, 3 ramp, 4 PN7, 5 PN15)
//   pat_a, pat_b       pattern words for even/odd sample slots
//   dma_data/valid/ready  DMA beat input, accepted when valid && ready
//   dac_data           registered samples to the framer, sample 0 in LSBs
//   underflow(_clr)    sticky DMA underflow flag and its clear pulse
module ad_ip_jesd204_tpl_dac_channel_src #(
    parameter int DATA_PATH_WIDTH      = 4,
    parameter int CONVERTER_RESOLUTION = 16
) (
    input  logic                                          clk,
    input  logic                                          reset,
    input  logic                                          enable,
    input  logic [2:0]                                    data_sel,
    input  logic [CONVERTER_RESOLUTION-1:0]               pat_a,
    input  logic [CONVERTER_RESOLUTION-1:0]               pat_b,
    input  logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dma_data,
    input  logic                                          dma_valid,
    output logic                                          dma_ready,
    output logic [DATA_PATH_WIDTH*CONVERTER_RESOLUTION-1:0] dac_data,
    output logic                                          underflow,
    input  logic                                          underflow_clr
);
    localparam int RES = CONVERTER_RESOLUTION;
    localparam int W   = DATA_PATH_WIDTH * RES;

    logic [W-1:0]   dac_q, dac_d;
    logic [RES-1:0] cnt_q, cnt_d, base;
    logic [14:0]    pn_q, pn_d, seed;
    logic [2:0]     sel_q, sel_d;
    logic           uf_q, uf_d, entry;
    logic [W+14:0]  seq;

    // Bits [14:0] hold the history (oldest at bit 0); each following bit is
    // the next serial PN bit, so a whole beat is unrolled in one cycle.
    function automatic logic [W+14:0] pn_seq(input logic [14:0] h, input logic pn7);
        logic [W+14:0] s;
        s = '0;
        s[14:0] = h;
        for (int k = 0; k < W; k++)
            s[15+k] = pn7 ? s[k+8] ^ s[k+9] : s[k] ^ s[k+1];
        return s;
    endfunction

    always_comb begin
        entry = enable && (data_sel != sel_q);
        base  = entry ? '0 : cnt_q;
        seed  = entry ? '1 : pn_q;
        seq   = pn_seq(seed, data_sel == 3'd4);
        dac_d = '0;
        cnt_d = '0;
        pn_d  = '1;
        sel_d = enable ? data_sel : sel_q;
        uf_d  = uf_q & ~underflow_clr;
        if (enable) begin
            case (data_sel)
                3'd0: begin
                    dac_d = dma_valid ? dma_data : '0;
                    uf_d  = uf_d | ~dma_valid;
                end
                3'd2: for (int i = 0; i < DATA_PATH_WIDTH; i++)
                    dac_d[i*RES +: RES] = (i % 2 == 1) ? pat_b : pat_a;
                3'd3: begin
                    for (int i = 0; i < DATA_PATH_WIDTH; i++)
                        dac_d[i*RES +: RES] = base + RES'(i);
                    cnt_d = base + RES'(DATA_PATH_WIDTH);
                end
                3'd4, 3'd5: begin
                    // Earliest bit of each sample lands in its MSB.
                    for (int i = 0; i < DATA_PATH_WIDTH; i++)
                        for (int j = 0; j < RES; j++)
                            dac_d[i*RES + RES-1-j] = seq[15 + i*RES + j];
                    pn_d = seq[W+14:W];
                end
                default: dac_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_q <= '0;
            cnt_q <= '0;
            pn_q  <= '1;
            sel_q <= 3'd1;
            uf_q  <= 1'b0;
        end else begin
            dac_q <= dac_d;
            cnt_q <= cnt_d;
            pn_q  <= pn_d;
            sel_q <= sel_d;
            uf_q  <= uf_d;
        end
    end

    assign dma_ready = enable && (data_sel == 3'd0) && !reset;
    assign dac_data  = dac_q;
    assign underflow = uf_q;
endmodule

// File: tb/tb_ad_ip_jesd204_tpl_dac_channel_src.sv
// tb_ad_ip_jesd204_tpl_dac_channel_src: table vectors plus scoreboarded sequences against a bit-serial model
module tb_ad_ip_jesd204_tpl_dac_channel_src;
    localparam int DPW = 4;
    localparam int RES = 16;
    localparam int W   = DPW * RES;

    logic           clk = 0;
    logic           reset = 1;
    logic           enable = 0;
    logic [2:0]     data_sel = 0;
    logic [RES-1:0] pat_a = 0, pat_b = 0;
    logic [W-1:0]   dma_data = 0;
    logic           dma_valid = 0;
    logic           dma_ready;
    logic [W-1:0]   dac_data;
    logic           underflow;
    logic           underflow_clr = 0;

    int total = 0;
    int bad = 0;

    ad_ip_jesd204_tpl_dac_channel_src #(.DATA_PATH_WIDTH(DPW), .CONVERTER_RESOLUTION(RES)) dut (
        .clk(clk), .reset(reset), .enable(enable), .data_sel(data_sel),
        .pat_a(pat_a), .pat_b(pat_b), .dma_data(dma_data), .dma_valid(dma_valid),
        .dma_ready(dma_ready), .dac_data(dac_data), .underflow(underflow),
        .underflow_clr(underflow_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         u;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        logic           rst, en;
        logic [2:0]     sel;
        logic [RES-1:0] pa, pb;
        logic [W-1:0]   dd;
        logic           dv, clr;
        logic [W-1:0]   ed;
        logic           eu, er;
    } vec_t;

    // Reference state: serial PN history with mh[0] the most recent bit.
    logic [RES-1:0] mc = 0;
    logic [14:0]    mh = '1;
    logic [2:0]     mp = 3'd1;
    logic           mu = 0;

    task automatic cmp(input string nm, input logic [W-1:0] a, input logic [W-1:0] e);
        total++;
        if (a !== e) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, a, e);
        end
    endtask

    task automatic model(output logic [W-1:0] d, output logic u);
        logic b;
        d = '0;
        if (reset) begin
            mc = 0; mh = '1; mp = 3'd1; mu = 0;
        end else if (!enable) begin
            mc = 0; mh = '1; mu = mu & ~underflow_clr;
        end else begin
            if (data_sel != mp) begin mc = 0; mh = '1; end
            mp = data_sel;
            mu = mu & ~underflow_clr;
            case (data_sel)
                3'd0: if (dma_valid) d = dma_data; else mu = 1;
                3'd2: for (int i = 0; i < DPW; i++) d[i*RES +: RES] = (i % 2 == 1) ? pat_b : pat_a;
                3'd3: for (int i = 0; i < DPW; i++) begin d[i*RES +: RES] = mc; mc = mc + 1'b1; end
                3'd4, 3'd5: for (int i = 0; i < DPW; i++)
                    for (int j = 0; j < RES; j++) begin
                        b = (data_sel == 3'd4) ? mh[6] ^ mh[5] : mh[14] ^ mh[13];
                        mh = {mh[13:0], b};
                        d[i*RES + RES-1-j] = b;
                    end
                default: d = '0;
            endcase
        end
        u = mu;
    endtask

    task automatic step(input string nm, input bit use_tab, input logic [W-1:0] td, input logic tuf,
                        output logic [W-1:0] ed);
        logic [W-1:0] md;
        logic         mo;
        exp_t         e;
        model(md, mo);
        e.d = use_tab ? td : md;
        e.u = use_tab ? tuf : mo;
        sb.push_back(e);
        ed = e.d;
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", nm);
        end else begin
            e = sb.pop_front();
            cmp({nm, "_data"}, dac_data, e.d);
            cmp({nm, "_uf"}, W'(underflow), W'(e.u));
        end
    endtask

    vec_t tab[19];
    logic [W-1:0] ed, pn15_first;
    localparam logic [W-1:0] D0 = 64'h0123_4567_89AB_CDEF;
    localparam logic [W-1:0] D1 = 64'hFEDC_BA98_7654_3210;
    localparam logic [W-1:0] D3 = 64'h8000_7FFF_0001_FFFE;
    localparam logic [W-1:0] D4 = 64'h5A5A_A5A5_1111_EEEE;
    localparam logic [W-1:0] R0 = 64'h0003_0002_0001_0000;
    localparam logic [W-1:0] R1 = 64'h0007_0006_0005_0004;

    initial begin
        tab[0]  = '{1, 1, 0, 0, 0, D0, 1, 0, '0, 0, 0};
        tab[1]  = '{0, 1, 2, 16'h1234, 16'hABCD, '0, 0, 0, 64'hABCD_1234_ABCD_1234, 0, 0};
        tab[2]  = '{0, 1, 2, 16'h1234, 16'hABCD, '0, 0, 0, 64'hABCD_1234_ABCD_1234, 0, 0};
        tab[3]  = '{0, 1, 0, 0, 0, D0, 1, 0, D0, 0, 1};
        tab[4]  = '{0, 1, 0, 0, 0, D1, 1, 0, D1, 0, 1};
        tab[5]  = '{0, 1, 0, 0, 0, D1, 0, 0, '0, 1, 1};
        tab[6]  = '{0, 1, 0, 0, 0, D3, 1, 0, D3, 1, 1};
        tab[7]  = '{0, 1, 0, 0, 0, D4, 1, 1, D4, 0, 1};
        tab[8]  = '{0, 1, 0, 0, 0, D4, 0, 1, '0, 1, 1};
        tab[9]  = '{0, 1, 1, 0, 0, D4, 1, 0, '0, 1, 0};
        tab[10] = '{0, 1, 6, 0, 0, D4, 1, 0, '0, 1, 0};
        tab[11] = '{0, 1, 7, 0, 0, D4, 1, 1, '0, 0, 0};
        tab[12] = '{0, 0, 0, 0, 0, D4, 0, 0, '0, 0, 0};
        tab[13] = '{0, 1, 3, 0, 0, '0, 0, 0, R0, 0, 0};
        tab[14] = '{0, 1, 3, 0, 0, '0, 0, 0, R1, 0, 0};
        tab[15] = '{0, 1, 2, 16'hFFFF, 16'h0000, '0, 0, 0, 64'h0000_FFFF_0000_FFFF, 0, 0};
        tab[16] = '{0, 1, 3, 0, 0, '0, 0, 0, R0, 0, 0};
        tab[17] = '{0, 0, 3, 0, 0, '0, 0, 0, '0, 0, 0};
        tab[18] = '{0, 1, 3, 0, 0, '0, 0, 0, R0, 0, 0};

        #1;
        for (int i = 0; i < 19; i++) begin
            reset = tab[i].rst; enable = tab[i].en; data_sel = tab[i].sel;
            pat_a = tab[i].pa; pat_b = tab[i].pb; dma_data = tab[i].dd;
            dma_valid = tab[i].dv; underflow_clr = tab[i].clr;
            #1;
            cmp($sformatf("row%0d_ready", i), W'(dma_ready), W'(tab[i].er));
            step($sformatf("row%0d", i), 1, tab[i].ed, tab[i].eu, ed);
        end
        underflow_clr = 0;

        // Ramp from reset across the 16-bit wrap.
        reset = 1; step("ramp_rst", 1, '0, 0, ed);
        reset = 0; enable = 1; data_sel = 3;
        step("ramp_first", 1, R0, 0, ed);
        for (int n = 1; n < 16384; n++) step("ramp", 0, '0, 0, ed);
        step("ramp_wrap", 1, R0, 0, ed);
        step("ramp_after_wrap", 1, R1, 0, ed);

        // Reset pulse mid-stream restarts the ramp.
        reset = 1; step("ramp_midrst", 1, '0, 0, ed);
        reset = 0; step("ramp_restart", 1, R0, 0, ed);
        step("ramp_restart2", 0, '0, 0, ed);

        enable = 0; data_sel = 0; dma_valid = 1; dma_data = D0;
        #1;
        cmp("disabled_ready", W'(dma_ready), '0);
        step("disabled", 1, '0, 0, ed);

        // PN7 against the serial model.
        enable = 1; data_sel = 4; dma_valid = 0;
        step("pn7_first", 0, '0, 0, ed);
        cmp("pn7_slot0", W'(dac_data[15:0]), W'(16'h020C));
        for (int n = 1; n < 1000; n++) step("pn7", 0, '0, 0, ed);

        // PN15, detour through PN7, then PN15 must restart from its first word.
        data_sel = 5;
        step("pn15_first", 0, '0, 0, pn15_first);
        for (int n = 1; n < 20; n++) step("pn15", 0, '0, 0, ed);
        data_sel = 4;
        for (int n = 0; n < 3; n++) step("pn7_detour", 0, '0, 0, ed);
        data_sel = 5;
        step("pn15_restart", 0, '0, 0, ed);
        cmp("pn15_restart_word", dac_data, pn15_first);
        for (int n = 0; n < 10; n++) step("pn15_cont", 0, '0, 0, ed);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
